keycode_packer: RTL and testbench
=================================

// Module: keycode_packer
// PURPOSE
//  Keyboard-side counterpart of the keycode decode path: turns a vector of per-key "held" levels
//  into the 32-bit, 4-slot USB HID keycode word (slot 0 = bits 7:0) consumed by game logic.
//  Slots hold keys in press order; a release compacts later slots down. Used as the keyboard
//  model in simulation and as the on-board/debug key source (switches/buttons -> keycode).
// PARAMETERS
//  NUM_KEYS   10  width of key_on; index order fixed by keycode_pkg::KEY_* (W,A,S,D,E,SPACE,UP,DOWN,RIGHT,LEFT)
//  NUM_SLOTS  4   active keycode slots, legal 1..4; bytes at and above NUM_SLOTS are always 8'h00
// PORTS
//  Clk        in   1         single clock; all state on rising edge
//  Reset      in   1         asynchronous, active-high
//  key_on     in   NUM_KEYS  level per key, 1 = held; synchronous to Clk
//  keycode    out  32        packed HID keycodes, unused slots 8'h00
//  key_chg    out  1         1-cycle pulse in the cycle keycode shows a new value
//  slot_cnt   out  3         number of occupied slots, 0..NUM_SLOTS
//  overflow   out  1         high while a key press is waiting because all slots are full
// BEHAVIOUR
//  Reset (async): slots all 8'h00, tracked mask 0, slot_cnt 0, keycode 0, key_chg 0, overflow 0,
//   FSM = STEADY.
//  tracked[i] = 1 iff key i occupies a slot. rel = tracked & ~key_on; prs = key_on & ~tracked.
//  One event per cycle, releases before presses, lowest index first within each class:
//   - rel != 0: remove key r's slot, shift all higher slots down one, clear top slot, cnt-1.
//   - else prs != 0 and cnt < NUM_SLOTS: write KEYCODE[p] into slot[cnt], set tracked[p], cnt+1.
//   - else: no slot change.
//  Latency: key_on change before edge N -> keycode updated at edge N; k queued events take k cycles.
//  Release and press in the same cycle: release handled at edge N, press at N+1.
//  Key pressed then released before being slotted: never appears, no key_chg.
//  FSM: STEADY -> ROLLOVER when prs != 0 and cnt == NUM_SLOTS; ROLLOVER -> STEADY when that
//   condition clears (a release then the pending press is slotted, or the pending key lifts).
//   overflow = (state == ROLLOVER), registered.
//  keycode, key_chg and overflow are registered; key_chg = 1 iff next keycode != current keycode.
//  Reset mid-operation clears everything; still-held keys re-enter in index order, one per cycle.
// CONFIGURATION
//  ROLLOVER_ERR_EN defined: while in ROLLOVER, keycode presents 8'h01 (ErrorRollOver) in every
//   active slot (bytes >= NUM_SLOTS still 0); internal slots unchanged; real slots reappear on exit;
//   key_chg pulses on entry and exit.
//  Not defined: keycode always shows the real slots; rollover indicated only by overflow.
// STRUCTURE
//  keycode_pkg: KEY_* index localparams, KEYCODE[NUM_KEYS] table (1A,04,16,07,08,2C,52,51,4F,50),
//   HC_ERR_ROLLOVER = 8'h01, typedef enum logic {STEADY, ROLLOVER} kp_state_t.
//  Sub-module lowest_one_finder (parameterised width -> found flag + index), two instances (rel, prs).
// TESTING
//  1 Reset held, key_on = 0 -> keycode 0, slot_cnt 0, key_chg 0, overflow 0; assert Reset mid-run -> all 0 same cycle.
//  2 key_on = W -> next edge keycode 32'h0000001A, key_chg one cycle, slot_cnt 1; release -> 0, key_chg.
//  3 W and A together -> edge1 32'h0000001A, edge2 32'h0000041A; drop W -> 32'h00000004.
//  4 W,A,S,D held then E -> 32'h0716041A, overflow 1 from next edge; drop A -> 32'h0007161A,
//    then 32'h0807161A, overflow 0.
//  5 ROLLOVER_ERR_EN defined, repeat 4 -> 32'h01010101 while overflow, then 32'h0007161A, 32'h0807161A.
//  6 slot 0 = W; same cycle drop W and press SPACE -> 32'h00000000 then 32'h0000002C; NUM_SLOTS=2 -> bytes 3:2 always 0.

Source files
------------

// File: rtl/keycode_pkg.sv
// Shared constants for the keycode packer: key index order, HID codes,
// and the rollover FSM state type.
package keycode_pkg;

    localparam int KEY_W     = 0;
    localparam int KEY_A     = 1;
    localparam int KEY_S     = 2;
    localparam int KEY_D     = 3;
    localparam int KEY_E     = 4;
    localparam int KEY_SPACE = 5;
    localparam int KEY_UP    = 6;
    localparam int KEY_DOWN  = 7;
    localparam int KEY_RIGHT = 8;
    localparam int KEY_LEFT  = 9;

    // HID usage code per key index; entry 0 is the rightmost byte
    localparam logic [9:0][7:0] KEYCODE = {
        8'h50, 8'h4F, 8'h51, 8'h52, 8'h2C,
        8'h08, 8'h07, 8'h16, 8'h04, 8'h1A
    };

    localparam logic [7:0] HC_ERR_ROLLOVER = 8'h01;

    typedef enum logic {
        STEADY,
        ROLLOVER
    } kp_state_t;

endpackage

// File: rtl/lowest_one_finder.sv
// Priority finder: flags whether any bit is set and returns
// the index of the lowest set bit.
module lowest_one_finder #(
    parameter int WIDTH = 10,
    parameter int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic             found,
    output logic [IW-1:0]    idx
);

    // scan from the top so the lowest set bit wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/keycode_packer.sv
// Packs held keys into a 4-slot HID keycode word in press order.
// Optional macro ROLLOVER_ERR_EN: show ErrorRollOver in all active slots while full.
module keycode_packer
    import keycode_pkg::*;
#(
    parameter int NUM_KEYS  = 10,
    parameter int NUM_SLOTS = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NUM_KEYS-1:0] key_on,
    output logic [31:0]         keycode,
    output logic                key_chg,
    output logic [2:0]          slot_cnt,
    output logic                overflow
);

    localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    logic [3:0][7:0]     slot_q, slot_d;
    logic [3:0][7:0]     shifted;
    logic [NUM_KEYS-1:0] tracked_q, tracked_d;
    logic [NUM_KEYS-1:0] rel, prs;
    logic [2:0]          cnt_q, cnt_d;
    kp_state_t           state_q, state_d;
    logic [31:0]         keycode_q, keycode_d;
    logic                key_chg_q;
    logic                rel_found, prs_found;
    logic [IW-1:0]       rel_idx, prs_idx;

    assign rel     = tracked_q & ~key_on;
    assign prs     = key_on & ~tracked_q;
    assign shifted = {8'h00, slot_q[3:1]};

    lowest_one_finder #(.WIDTH(NUM_KEYS), .IW(IW)) u_rel (
        .vec   (rel),
        .found (rel_found),
        .idx   (rel_idx)
    );

    lowest_one_finder #(.WIDTH(NUM_KEYS), .IW(IW)) u_prs (
        .vec   (prs),
        .found (prs_found),
        .idx   (prs_idx)
    );

    // one slot event per cycle, rollover state and displayed word
    always_comb begin
        logic shifting;
        logic pend;
        slot_d    = slot_q;
        tracked_d = tracked_q;
        cnt_d     = cnt_q;
        shifting  = 1'b0;
        if (rel_found) begin
            tracked_d[rel_idx] = 1'b0;
            cnt_d = cnt_q - 3'd1;
            for (int j = 0; j < 4; j++) begin
                if (slot_q[j] == KEYCODE[rel_idx]) shifting = 1'b1;
                if (shifting) slot_d[j] = shifted[j];
            end
        end else if (prs_found && cnt_q < 3'(NUM_SLOTS)) begin
            slot_d[cnt_q[1:0]] = KEYCODE[prs_idx];
            tracked_d[prs_idx] = 1'b1;
            cnt_d = cnt_q + 3'd1;
        end
        pend    = |(key_on & ~tracked_d);
        state_d = (pend && cnt_d == 3'(NUM_SLOTS)) ? ROLLOVER : STEADY;
        keycode_d = slot_d;
`ifdef ROLLOVER_ERR_EN
        if (state_d == ROLLOVER) begin
            for (int j = 0; j < 4; j++) begin
                keycode_d[8*j +: 8] = (j < NUM_SLOTS) ? HC_ERR_ROLLOVER : 8'h00;
            end
        end
`endif
    end

    // state and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            slot_q    <= '0;
            tracked_q <= '0;
            cnt_q     <= '0;
            state_q   <= STEADY;
            keycode_q <= '0;
            key_chg_q <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            tracked_q <= tracked_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            keycode_q <= keycode_d;
            key_chg_q <= (keycode_d != keycode_q);
        end
    end

    assign keycode  = keycode_q;
    assign key_chg  = key_chg_q;
    assign slot_cnt = cnt_q;
    assign overflow = (state_q == ROLLOVER);

endmodule

// File: tb/tb_keycode_packer.sv
// Bench for keycode_packer: 4-slot and 2-slot instances against a
// press-order queue model, directed steps then random key activity.
module tb_keycode_packer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [9:0]  key_on = '0;
    logic [31:0] kc4, kc2;
    logic        chg4, chg2, ov4, ov2;
    logic [2:0]  cnt4, cnt2;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 Clk = ~Clk;

    keycode_packer #(.NUM_KEYS(10), .NUM_SLOTS(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .key_on(key_on), .keycode(kc4),
        .key_chg(chg4), .slot_cnt(cnt4), .overflow(ov4)
    );

    keycode_packer #(.NUM_KEYS(10), .NUM_SLOTS(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .key_on(key_on), .keycode(kc2),
        .key_chg(chg2), .slot_cnt(cnt2), .overflow(ov2)
    );

    logic [7:0]  codes [10] = '{8'h1A, 8'h04, 8'h16, 8'h07, 8'h08,
                               8'h2C, 8'h52, 8'h51, 8'h4F, 8'h50};
    int          mq [2][4];
    int          mlen [2];
    int          mns [2] = '{4, 2};
    logic [31:0] mkc [2];
    logic        mchg [2];
    logic        mov [2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit held(input int d, input int k);
        for (int s = 0; s < mlen[d]; s++) if (mq[d][s] == k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic mreset(input int d);
        mlen[d] = 0;
        mkc[d]  = '0;
        mchg[d] = 1'b0;
        mov[d]  = 1'b0;
    endtask

    task automatic mstep(input int d, input logic [9:0] kon);
        int r, p, pos;
        logic [31:0] w;
        r = -1;
        p = -1;
        for (int i = 0; i < 10; i++) begin
            if (held(d, i) && !kon[i] && r < 0) r = i;
            if (!held(d, i) && kon[i] && p < 0) p = i;
        end
        if (r >= 0) begin
            pos = 0;
            for (int s = 0; s < mlen[d]; s++) if (mq[d][s] == r) pos = s;
            for (int s = pos; s < mlen[d] - 1; s++) mq[d][s] = mq[d][s+1];
            mlen[d]--;
        end else if (p >= 0 && mlen[d] < mns[d]) begin
            mq[d][mlen[d]] = p;
            mlen[d]++;
        end
        mov[d] = 1'b0;
        if (mlen[d] == mns[d])
            for (int i = 0; i < 10; i++) if (kon[i] && !held(d, i)) mov[d] = 1'b1;
        w = '0;
        for (int s = 0; s < mlen[d]; s++) w[8*s +: 8] = codes[mq[d][s]];
`ifdef ROLLOVER_ERR_EN
        if (mov[d]) begin
            w = '0;
            for (int s = 0; s < mns[d]; s++) w[8*s +: 8] = 8'h01;
        end
`endif
        mchg[d] = (w != mkc[d]);
        mkc[d]  = w;
    endtask

    task automatic step();
        @(posedge Clk);
        for (int d = 0; d < 2; d++) begin
            if (Reset) mreset(d);
            else mstep(d, key_on);
        end
        #1;
        chk("kc4", kc4, mkc[0]);
        chk("chg4", 32'(chg4), 32'(mchg[0]));
        chk("cnt4", 32'(cnt4), 32'(mlen[0]));
        chk("ov4", 32'(ov4), 32'(mov[0]));
        chk("kc2", kc2, mkc[1]);
        chk("chg2", 32'(chg2), 32'(mchg[1]));
        chk("cnt2", 32'(cnt2), 32'(mlen[1]));
        chk("ov2", 32'(ov2), 32'(mov[1]));
        chk("kc2_hi", 32'(kc2[31:16]), 32'h0);
    endtask

    initial begin
        mreset(0);
        mreset(1);
        #1;
        chk("rst_kc", kc4, 32'h0);
        chk("rst_cnt", 32'(cnt4), 32'h0);
        chk("rst_chg", 32'(chg4), 32'h0);
        chk("rst_ov", 32'(ov4), 32'h0);
        step();
        step();
        Reset = 1'b0;

        key_on = 10'b00_0000_0001;
        step();
        chk("w_kc", kc4, 32'h0000001A);
        chk("w_chg", 32'(chg4), 32'h1);
        chk("w_cnt", 32'(cnt4), 32'h1);
        step();
        chk("w_chg_off", 32'(chg4), 32'h0);
        key_on = '0;
        step();
        chk("w_rel_kc", kc4, 32'h0);
        chk("w_rel_chg", 32'(chg4), 32'h1);

        key_on = 10'b00_0000_0011;
        step();
        chk("wa_e1", kc4, 32'h0000001A);
        step();
        chk("wa_e2", kc4, 32'h0000041A);
        key_on = 10'b00_0000_0010;
        step();
        chk("wa_dropw", kc4, 32'h00000004);
        key_on = '0;
        step();

        key_on = 10'b00_0000_1111;
        repeat (4) step();
        chk("wasd", kc4, 32'h0716041A);
        key_on = 10'b00_0001_1111;
        step();
        chk("ovf_set", 32'(ov4), 32'h1);
`ifdef ROLLOVER_ERR_EN
        chk("ovf_kc", kc4, 32'h01010101);
`else
        chk("ovf_kc", kc4, 32'h0716041A);
`endif
        step();
        key_on = 10'b00_0001_1101;
        step();
        chk("drop_a", kc4, 32'h0007161A);
        step();
        chk("e_in", kc4, 32'h0807161A);
        chk("ovf_clr", 32'(ov4), 32'h0);

        key_on = '0;
        repeat (5) step();
        key_on = 10'b00_0000_0001;
        step();
        key_on = 10'b00_0010_0000;
        step();
        chk("swap_rel", kc4, 32'h0);
        step();
        chk("swap_prs", kc4, 32'h0000002C);

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(2, 0) == 0) key_on[$urandom_range(9, 0)] ^= 1'b1;
            if ($urandom_range(7, 0) == 0) key_on[$urandom_range(9, 0)] ^= 1'b1;
            if (c == 200) begin
                key_on = 10'($urandom) | 10'b00_0000_0001;
                repeat (3) step();
                #2;
                Reset = 1'b1;
                #1;
                chk("mid_rst_kc", kc4, 32'h0);
                chk("mid_rst_cnt", 32'(cnt4), 32'h0);
                chk("mid_rst_ov", 32'(ov4), 32'h0);
                chk("mid_rst_chg", 32'(chg4), 32'h0);
                step();
                Reset = 1'b0;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
